// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller between the PC register and the IF/ID boundary.
// Optional FETCH_ADEL_EN: raise an address-error fault instead of fetching an unaligned PC.
module if_fetch_ctrl #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             id_stall,
    input  logic             flush,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_inst,
    output logic             if_adel,
    output logic             fetch_stall
);

    // state     | meaning
    // S_REQ     | request pc_in on the bus, waiting for addr_ok
    // S_WAIT    | request accepted, waiting for data_ok
    // S_OUT     | instruction held for ID until it is consumed
    // S_DISCARD | flushed while a read is in flight, swallow its data_ok
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_DISCARD} state_t;

    state_t           state;
    logic [WIDTH-1:0] pend_pc;
    logic             misaligned;

`ifdef FETCH_ADEL_EN
    assign misaligned = (pc_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign inst_req  = (state == S_REQ) && !misaligned;
    assign inst_addr = pc_in;

    // A flush releases the PC register so it can load the redirect target.
    always_comb begin
        fetch_stall = 1'b1;
        if (flush)
            fetch_stall = 1'b0;
        else if (state == S_OUT)
            fetch_stall = id_stall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            pend_pc  <= '0;
            if_valid <= 1'b0;
            if_pc    <= RESET_PC;
            if_inst  <= '0;
            if_adel  <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (flush) begin
                        if (inst_req && inst_addr_ok)
                            state <= S_DISCARD;
                    end else if (misaligned) begin
                        state    <= S_OUT;
                        if_pc    <= pc_in;
                        if_inst  <= '0;
                        if_adel  <= 1'b1;
                        if_valid <= 1'b1;
                    end else if (inst_addr_ok) begin
                        state   <= S_WAIT;
                        pend_pc <= pc_in;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        if (flush) begin
                            state <= S_REQ;
                        end else begin
                            state    <= S_OUT;
                            if_pc    <= pend_pc;
                            if_inst  <= inst_rdata;
                            if_adel  <= 1'b0;
                            if_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        state <= S_DISCARD;
                    end
                end
                S_OUT: begin
                    if (flush || !id_stall) begin
                        state    <= S_REQ;
                        if_valid <= 1'b0;
                        if_adel  <= 1'b0;
                    end
                end
                S_DISCARD: begin
                    if (inst_data_ok)
                        state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule
